alu_issue_arbiter: RTL

Shares the single combinational EX-stage ALU between two requesters: port 0 is the pipeline EX stage and port 1 is the debug/test unit. The block arbitrates round-robin and registers the winning request into an issue stage that drives the ALU. It captures the ALU result into a response register, returning it to the requester tagged with that requester's ID. Valid/ready handshakes on both sides; two-stage pipeline with full backpressure.

---
 rtl/alu_issue_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin sharing of the EX-stage ALU between the pipeline (port 0) and the debug unit (port 1),
// with issue and response registers. Define ALU_ARB_STATS_EN to add saturating per-port grant counters.
module alu_issue_arbiter #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 32
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int NB_CNT  = 16
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [NB_OP-1:0]   i_req0_opcode,
  input  logic [NB_DATA-1:0] i_req0_op1,
  input  logic [NB_DATA-1:0] i_req0_op2,
  input  logic [4:0]         i_req0_shamt,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [NB_OP-1:0]   i_req1_opcode,
  input  logic [NB_DATA-1:0] i_req1_op1,
  input  logic [NB_DATA-1:0] i_req1_op2,
  input  logic [4:0]         i_req1_shamt,
  output logic [NB_OP-1:0]   o_alu_opcode,
  output logic [NB_DATA-1:0] o_alu_operand1,
  output logic [NB_DATA-1:0] o_alu_operand2,
  output logic [4:0]         o_alu_shamt,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_rsp_valid,
  output logic               o_rsp_id,
  output logic [NB_DATA-1:0] o_rsp_data,
  input  logic               i_rsp_ready
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NB_CNT-1:0]  o_grant_cnt0,
  output logic [NB_CNT-1:0]  o_grant_cnt1
`endif
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  logic  s1_valid;
  port_e s1_id;
  port_e last_grant;
  logic  s2_take;
  logic  s1_free;
  logic  grant0;
  logic  grant1;

  // Grants are gated by s1_free so readies fall together when both stages are stalled.
  always_comb begin
    s2_take = !o_rsp_valid || i_rsp_ready;
    s1_free = !s1_valid || s2_take;
    grant0  = s1_free && i_req0_valid && (!i_req1_valid || last_grant == PORT1);
    grant1  = s1_free && i_req1_valid && (!i_req0_valid || last_grant == PORT0);
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_rsp_data  <= '0;
    end else if (s2_take) begin
      o_rsp_valid <= s1_valid;
      if (s1_valid) begin
        o_rsp_id   <= s1_id;
        o_rsp_data <= i_alu_result;
      end
    end
  end

  // The ALU-facing registers keep their last payload when s1 drains.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid       <= 1'b0;
      s1_id          <= PORT0;
      o_alu_opcode   <= '0;
      o_alu_operand1 <= '0;
      o_alu_operand2 <= '0;
      o_alu_shamt    <= '0;
    end else if (s1_free) begin
      s1_valid <= grant0 || grant1;
      if (grant0) begin
        s1_id          <= PORT0;
        o_alu_opcode   <= i_req0_opcode;
        o_alu_operand1 <= i_req0_op1;
        o_alu_operand2 <= i_req0_op2;
        o_alu_shamt    <= i_req0_shamt;
      end else if (grant1) begin
        s1_id          <= PORT1;
        o_alu_opcode   <= i_req1_opcode;
        o_alu_operand1 <= i_req1_op1;
        o_alu_operand2 <= i_req1_op2;
        o_alu_shamt    <= i_req1_shamt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant <= PORT1;
    end else if (grant0 || grant1) begin
      last_grant <= grant1 ? PORT1 : PORT0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_grant_cnt0 <= '0;
      o_grant_cnt1 <= '0;
    end else begin
      if (grant0 && o_grant_cnt0 != '1) o_grant_cnt0 <= o_grant_cnt0 + NB_CNT'(1);
      if (grant1 && o_grant_cnt1 != '1) o_grant_cnt1 <= o_grant_cnt1 + NB_CNT'(1);
    end
  end
`endif

endmodule
